// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared types and constants for on-chip memory bus initiators
package mem_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_FINISH
   } dma_state_e;

   localparam logic [3:0] WMASK_FULL = 4'b1111;
   localparam int         WORD_BYTES = 4;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      logic        wen;
      logic        ren;
   } bus_req_t;

   localparam bus_req_t BUS_REQ_IDLE = '0;

endpackage

// File: rtl/mem_dma_engine_if.sv
// rtl/mem_dma_engine_if.sv - on-chip memory bus signals with initiator/responder views
interface mem_dma_engine_if;

   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wmask;
   logic        wen;
   logic        ren;
   logic [31:0] rdata;
   logic        done;

   modport master (
      output addr, wdata, wmask, wen, ren,
      input  rdata, done
   );

   modport slave (
      input  addr, wdata, wmask, wen, ren,
      output rdata, done
   );

endinterface

// File: rtl/bus_xact_tracker.sv
// rtl/bus_xact_tracker.sv - per-request done qualification and timeout counter
module bus_xact_tracker #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic req_start,
   input  logic req_active,
   input  logic done,
   output logic accepted,
   output logic timed_out
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] elapsed;

   // A responder may still be holding done from the previous transaction,
   // so done is never trusted in the first cycle of a request.
   always_comb begin
      elapsed   = req_start ? '0 : cnt_q;
      accepted  = req_active && done && !req_start;
      timed_out = req_active && !accepted && (elapsed == CW'(TIMEOUT_CYCLES - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (req_active) begin
         cnt_q <= elapsed + 1'b1;
      end
   end

endmodule

// File: rtl/mem_dma_engine.sv
// rtl/mem_dma_engine.sv - memory bus DMA initiator: block copy or fill of 32-bit words
module mem_dma_engine
   import mem_bus_pkg::*;
#(
   parameter int LEN_BITS       = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                fill_mode,
   input  logic [31:0]         src_addr,
   input  logic [31:0]         dst_addr,
   input  logic [LEN_BITS-1:0] len_words,
   input  logic [31:0]         fill_value,
   output logic                busy,
   output logic                finished,
   output logic                error,
   mem_dma_engine_if.master    bus
);

   dma_state_e          state_q, state_n;
   logic [31:0]         src_q, src_n;
   logic [31:0]         dst_q, dst_n;
   logic [LEN_BITS-1:0] len_q, len_n;
   logic [LEN_BITS-1:0] count_q, count_n;
   logic                fill_q, fill_n;
   logic [31:0]         fval_q, fval_n;
   logic [31:0]         buf_q, buf_n;
   logic                error_q, error_n;
   logic                first_q, first_n;
   bus_req_t            req_q, req_n;

   logic                accepted;
   logic                timed_out;

   bus_xact_tracker #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_tracker (
      .clk        (clk),
      .rst        (rst),
      .req_start  (first_q),
      .req_active (req_q.ren | req_q.wen),
      .done       (bus.done),
      .accepted   (accepted),
      .timed_out  (timed_out)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_n;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         count_q <= '0;
         fill_q  <= 1'b0;
         fval_q  <= '0;
         buf_q   <= '0;
         error_q <= 1'b0;
         first_q <= 1'b0;
         req_q   <= BUS_REQ_IDLE;
      end else begin
         src_q   <= src_n;
         dst_q   <= dst_n;
         len_q   <= len_n;
         count_q <= count_n;
         fill_q  <= fill_n;
         fval_q  <= fval_n;
         buf_q   <= buf_n;
         error_q <= error_n;
         first_q <= first_n;
         req_q   <= req_n;
      end
   end

   always_comb begin
      state_n = state_q;
      src_n   = src_q;
      dst_n   = dst_q;
      len_n   = len_q;
      count_n = count_q;
      fill_n  = fill_q;
      fval_n  = fval_q;
      buf_n   = buf_q;
      error_n = error_q;
      first_n = 1'b0;
      req_n   = BUS_REQ_IDLE;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               src_n   = src_addr & 32'hffff_fffc;
               dst_n   = dst_addr & 32'hffff_fffc;
               len_n   = len_words;
               count_n = '0;
               fill_n  = fill_mode;
               fval_n  = fill_value;
               error_n = 1'b0;
               if (len_words == '0) begin
                  state_n = ST_FINISH;
               end else begin
                  state_n = fill_mode ? ST_WRITE : ST_READ;
                  first_n = 1'b1;
               end
            end
         end
         ST_READ: begin
            if (timed_out) begin
               error_n = 1'b1;
               state_n = ST_FINISH;
            end else if (accepted) begin
               buf_n   = bus.rdata;
               src_n   = src_q + 32'(WORD_BYTES);
               state_n = ST_WRITE;
               first_n = 1'b1;
            end
         end
         ST_WRITE: begin
            if (timed_out) begin
               error_n = 1'b1;
               state_n = ST_FINISH;
            end else if (accepted) begin
               dst_n   = dst_q + 32'(WORD_BYTES);
               count_n = count_q + 1'b1;
               if (count_n == len_q) begin
                  state_n = ST_FINISH;
               end else begin
                  // Fill stays in WRITE; first_n re-arms the stale-done guard.
                  state_n = fill_q ? ST_WRITE : ST_READ;
                  first_n = 1'b1;
               end
            end
         end
         ST_FINISH: begin
            state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase

      // Bus request is built from the next state so it is registered and
      // holds steady for the whole request.
      if (state_n == ST_READ) begin
         req_n.ren  = 1'b1;
         req_n.addr = src_n;
      end else if (state_n == ST_WRITE) begin
         req_n.wen   = 1'b1;
         req_n.addr  = dst_n;
         req_n.wdata = fill_n ? fval_n : buf_n;
         req_n.wmask = WMASK_FULL;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign finished  = (state_q == ST_FINISH);
   assign error     = error_q;

   assign bus.addr  = req_q.addr;
   assign bus.wdata = req_q.wdata;
   assign bus.wmask = req_q.wmask;
   assign bus.wen   = req_q.wen;
   assign bus.ren   = req_q.ren;

endmodule
